// File: rtl/compare_scan_alarm.sv
// Sequential channel comparator. It scans N snapshotted operand pairs one channel
// per cycle, counts mismatches and raises a sticky alarm when the count reaches a threshold.
module compare_scan_alarm #(
  parameter int unsigned W  = 2,
  parameter int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N + 1),
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic            clear,
  input  logic [1:0]      mode,
  input  logic [CW-1:0]   thresh,
  input  logic [N*W-1:0]  a_vec,
  input  logic [N*W-1:0]  b_vec,
  output logic            busy,
  output logic            done,
  output logic            alarm,
  output logic [CW-1:0]   mismatch_cnt,
  output logic [IW-1:0]   first_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  logic [N*W-1:0]  a_q;
  logic [N*W-1:0]  b_q;
  logic [1:0]      mode_q;
  logic [CW-1:0]   thresh_q;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            found;
  logic [IW-1:0]   first_q;

  logic [W-1:0]    a_ch;
  logic [W-1:0]    b_ch;
  logic            mism;
  logic [CW-1:0]   cnt_nx;
  logic            found_nx;
  logic [IW-1:0]   first_nx;
  logic            last;

  // Evaluate the channel currently addressed by idx
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx == IW'(k)) begin
        a_ch = a_q[k*W +: W];
        b_ch = b_q[k*W +: W];
      end
    end
    mism = 1'b0;
    case (mode_q)
      2'b00:   mism = (a_ch != b_ch);
      2'b01:   mism = (a_ch >  b_ch);
      2'b10:   mism = (a_ch <  b_ch);
      default: mism = (a_ch == b_ch);
    endcase
    cnt_nx   = cnt + CW'(mism);
    found_nx = found | mism;
    first_nx = found ? first_q : idx;
    last     = (idx == IW'(N - 1));
  end

  // Control FSM; results are published on the edge entering DONE so they are valid alongside done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= '0;
      thresh_q     <= '0;
      idx          <= '0;
      cnt          <= '0;
      found        <= 1'b0;
      first_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      alarm        <= 1'b0;
      mismatch_cnt <= '0;
      first_idx    <= '0;
    end else if (clear) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      found        <= 1'b0;
      first_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      alarm        <= 1'b0;
      mismatch_cnt <= '0;
      first_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            state    <= SCAN;
            a_q      <= a_vec;
            b_q      <= b_vec;
            mode_q   <= mode;
            thresh_q <= thresh;
            idx      <= '0;
            cnt      <= '0;
            found    <= 1'b0;
            first_q  <= '0;
            alarm    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          cnt   <= cnt_nx;
          found <= found_nx;
          if (mism && !found) begin
            first_q <= idx;
          end
          if (last) begin
            state        <= DONE;
            done         <= 1'b1;
            mismatch_cnt <= cnt_nx;
            first_idx    <= found_nx ? first_nx : '0;
            alarm        <= (thresh_q != '0) && (cnt_nx >= thresh_q);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/compare_scan_alarm.md
COMPARE_SCAN_ALARM -- requirements
Module: compare_scan_alarm

Interface
REQ-001 Parameter W, 2, element width in bits per channel (W >= 1).
REQ-002 Parameter N, 4, channel count (N >= 2).
REQ-003 Parameter derived CW = $clog2(N+1), counter/threshold width; IW = $clog2(N), index width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 go  in  1  start request; sampled only in IDLE.
REQ-007 clear  in  1  synchronous abort/clear; priority over go.
REQ-008 mode  in  2  compare mode, latched at go acceptance.
REQ-009 thresh  in  CW  alarm threshold, latched at go acceptance.
REQ-010 a_vec  in  N*W  operand A; channel k at bits [k*W +: W].
REQ-011 b_vec  in  N*W  operand B; same packing.
REQ-012 busy  out  1  high while in SCAN or DONE.
REQ-013 done  out  1  one-cycle pulse at scan completion.
REQ-014 alarm  out  1  sticky alarm flag.
REQ-015 mismatch_cnt  out  CW  number of mismatching channels from last completed scan.
REQ-016 first_idx  out  IW  lowest mismatching channel index from last completed scan.

Function
REQ-017 FSM states IDLE, SCAN, DONE; IDLE -> SCAN on go=1 and clear=0; SCAN -> DONE after channel N-1 is evaluated; DONE -> IDLE unconditionally.
REQ-018 Go acceptance (IDLE, go=1, clear=0) snapshots a_vec, b_vec, mode, thresh into internal registers, sets idx=0, cnt=0, found=0, and clears alarm; later input changes do not affect the scan.
REQ-019 SCAN evaluates exactly one channel per cycle, idx 0..N-1 ascending; idx increments by 1, no wrap beyond N-1.
REQ-020 Mismatch per channel, unsigned: mode 00 a!=b; 01 a>b; 10 a<b; 11 a==b.
REQ-021 On mismatch: cnt increments by 1 (cannot overflow, CW sized for N); if found=0, captures idx as first index and sets found=1.
REQ-022 Latency: go accepted at edge 0 -> SCAN for edges 1..N -> done=1 during cycle after edge N, busy=1 for N+1 cycles total.
REQ-023 In DONE: mismatch_cnt <= cnt; first_idx <= captured index if found, else 0; alarm <= 1 iff thresh != 0 and cnt >= thresh.
REQ-024 mismatch_cnt, first_idx, alarm hold their values in IDLE until next go acceptance (alarm) / next DONE (cnt, idx) or clear.
REQ-025 go while busy=1 is ignored; no queuing.
REQ-026 clear=1 in any state: next state IDLE, alarm=0, mismatch_cnt=0, first_idx=0, no done pulse; aborted scan results are discarded.
REQ-027 clear=1 and go=1 together in IDLE: clear wins, scan not started.
REQ-028 go held high continuously: new scan starts on the IDLE cycle following each DONE, i.e. every N+2 cycles.
REQ-029 thresh=0 disables alarm regardless of cnt.

Reset
REQ-030 reset=1 forces asynchronously: state IDLE, busy=0, done=0, alarm=0, mismatch_cnt=0, first_idx=0, idx=0, cnt=0, found=0.
REQ-031 Reset asserted mid-scan aborts immediately with no done pulse; operation resumes only via a new go after reset deasserts.

Verification (W=2, N=4)
REQ-032 Reset then idle, a_vec=0x00, b_vec=0x55, mode=00, thresh=1, go pulse -> busy 5 cycles, done at cycle 5, mismatch_cnt=4, first_idx=0, alarm=1.
REQ-033 a_vec=0xE4 (3,2,1,0), b_vec=0x99 (2,1,2,1), mode=01, thresh=3 -> mismatch_cnt=2, first_idx=2, alarm=0; repeat with thresh=2 -> alarm=1.
REQ-034 a_vec=b_vec=0xAA, mode=00, thresh=1 -> mismatch_cnt=0, first_idx=0, alarm=0; same with mode=11 -> mismatch_cnt=4, alarm=1.
REQ-035 Go accepted, then clear at cycle 2 -> no done pulse, busy=0 next cycle, alarm=0, mismatch_cnt=0; go+clear same cycle in IDLE -> no scan.
REQ-036 Go re-pulsed during SCAN and a_vec changed mid-scan -> single done, results match snapshot; reset asserted at cycle 3 -> all outputs 0 asynchronously, no done.
